// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game-level controller downstream of the ball movement stage.
// It owns the brick-visibility register that feeds back into the ball stage, accumulates a
// saturating score and runs the IDLE/RESET/PLAY/WON/LOST state machine.
//
// Ports:
//   clk        system clock (shared with the ball stage)
//   rst        asynchronous, active-high reset
//   start_btn  single-cycle start/restart pulse
//   lives_in   lives count from the ball stage
//   visible_in updated brick mask from the ball stage (1 = brick present)
//   visible    registered brick mask to the ball stage and the brick renderer
//   ball_rst   reset to the ball stage, high in every state except PLAY
//   score      accumulated score, saturates at 16'hFFFF
//   state      encoded state: IDLE=0, RESET=1, PLAY=2, WON=3, LOST=4
//   game_over  high in LOST
//   game_won   high in WON
module game_state_ctrl #(
  parameter int unsigned NUM_BLOCKS       = 56,
  parameter int unsigned POINTS_PER_BLOCK = 10,
  parameter int unsigned RST_CYCLES       = 4,
  parameter int unsigned START_LIVES      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_btn,
  input  logic [3:0]            lives_in,
  input  logic [NUM_BLOCKS-1:0] visible_in,
  output logic [NUM_BLOCKS-1:0] visible,
  output logic                  ball_rst,
  output logic [15:0]           score,
  output logic [2:0]            state,
  output logic                  game_over,
  output logic                  game_won
);

  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned PopW = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReset = 3'd1,
    StPlay  = 3'd2,
    StWon   = 3'd3,
    StLost  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_BLOCKS-1:0] vis_q, vis_d;
  logic [15:0]           score_q, score_d;
  logic [3:0]            prev_lives_q, prev_lives_d;
  logic                  ball_rst_q, ball_rst_d;
  logic                  game_over_q, game_over_d;
  logic                  game_won_q, game_won_d;

  // Bits only ever clear: a brick reappearing on visible_in is ignored.
  logic [NUM_BLOCKS-1:0] vis_keep;
  logic [NUM_BLOCKS-1:0] cleared;
  logic [PopW-1:0]       cleared_cnt;
  logic [31:0]           score_sum;
  logic [15:0]           score_sat;
  logic                  rst_done;

  // prev_lives is kept for the ball stage's bookkeeping but drives no output here.
  logic unused_prev_lives;
  assign unused_prev_lives = ^prev_lives_q;

  // Single-cycle popcount; synthesis balances the chain into an adder tree.
  function automatic logic [PopW-1:0] popcount(input logic [NUM_BLOCKS-1:0] v);
    logic [PopW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      acc = acc + PopW'(v[i]);
    end
    return acc;
  endfunction

  assign vis_keep    = vis_q & visible_in;
  assign cleared     = vis_q & ~visible_in;
  assign cleared_cnt = popcount(cleared);
  // Sum at 32 bits so the credit cannot wrap before saturation.
  assign score_sum   = 32'(score_q) + 32'(cleared_cnt) * POINTS_PER_BLOCK;
  assign score_sat   = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
  assign rst_done    = (cnt_q == CntW'(RST_CYCLES - 1));

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vis_q        <= '1;
      score_q      <= '0;
      prev_lives_q <= 4'(START_LIVES);
      ball_rst_q   <= 1'b1;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vis_q        <= vis_d;
      score_q      <= score_d;
      prev_lives_q <= prev_lives_d;
      ball_rst_q   <= ball_rst_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StWon, StLost: begin
        if (start_btn) state_d = StReset;
      end
      StReset: begin
        if (rst_done) state_d = StPlay;
      end
      StPlay: begin
        // Winning takes priority over losing the last life in the same cycle.
        if (vis_keep == '0)        state_d = StWon;
        else if (lives_in == 4'd0) state_d = StLost;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values and registered outputs, derived from the upcoming state.
  always_comb begin
    cnt_d        = cnt_q;
    vis_d        = vis_q;
    score_d      = score_q;
    prev_lives_d = prev_lives_q;
    case (state_q)
      StIdle, StWon, StLost: begin
        if (start_btn) begin
          cnt_d   = '0;
          score_d = '0;
          vis_d   = '1;
        end
      end
      StReset: begin
        cnt_d        = rst_done ? '0 : cnt_q + CntW'(1);
        prev_lives_d = 4'(START_LIVES);
      end
      StPlay: begin
        vis_d        = vis_keep;
        score_d      = score_sat;
        prev_lives_d = lives_in;
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    ball_rst_d  = (state_d != StPlay);
    game_over_d = (state_d == StLost);
    game_won_d  = (state_d == StWon);
  end

  assign visible   = vis_q;
  assign ball_rst  = ball_rst_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = game_over_q;
  assign game_won  = game_won_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  localparam int unsigned NB = 56;
  localparam logic [NB-1:0] AllOnes = '1;

  logic          clk;
  logic          rst;
  logic          start_btn, start_s;
  logic [3:0]    lives_in, lives_s;
  logic [NB-1:0] visible_in, vis_s;
  logic [NB-1:0] visible, visible_sat;
  logic          ball_rst, ball_rst_sat;
  logic [15:0]   score, score_sat;
  logic [2:0]    state, state_sat;
  logic          game_over, game_over_sat;
  logic          game_won, game_won_sat;

  int n_tests = 0;
  int n_fail  = 0;

  game_state_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .lives_in   (lives_in),
    .visible_in (visible_in),
    .visible    (visible),
    .ball_rst   (ball_rst),
    .score      (score),
    .state      (state),
    .game_over  (game_over),
    .game_won   (game_won)
  );

  // Large per-brick credit so one game reaches the 16-bit ceiling.
  game_state_ctrl #(
    .POINTS_PER_BLOCK (1200)
  ) u_sat (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_s),
    .lives_in   (lives_s),
    .visible_in (vis_s),
    .visible    (visible_sat),
    .ball_rst   (ball_rst_sat),
    .score      (score_sat),
    .state      (state_sat),
    .game_over  (game_over_sat),
    .game_won   (game_won_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a game on the main DUT and walk through the RESET window into PLAY.
  task automatic start_game();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst        = 1'b1;
    start_btn  = 1'b0;
    lives_in   = 4'd9;
    visible_in = AllOnes;
    start_s    = 1'b0;
    lives_s    = 4'd9;
    vis_s      = AllOnes;
    #2;
    check("rst_state",     64'(state), 64'd0);
    check("rst_visible",   64'(visible), 64'(AllOnes));
    check("rst_score",     64'(score), 64'd0);
    check("rst_ball_rst",  64'(ball_rst), 64'd1);
    check("rst_game_over", 64'(game_over), 64'd0);
    check("rst_game_won",  64'(game_won), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    tick();
    check("idle_hold", 64'(state), 64'd0);

    // Start: four RESET cycles with ball_rst high, then PLAY.
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("reset_entry_state", 64'(state), 64'd1);
    check("reset_entry_brst",  64'(ball_rst), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold_state", 64'(state), 64'd1);
      check("reset_hold_brst",  64'(ball_rst), 64'd1);
    end
    tick();
    check("play_state",   64'(state), 64'd2);
    check("play_brst",    64'(ball_rst), 64'd0);
    check("play_visible", 64'(visible), 64'(AllOnes));
    check("play_score",   64'(score), 64'd0);

    // Clear bricks 0 and 13.
    visible_in = AllOnes & ~((56'd1 << 0) | (56'd1 << 13));
    tick();
    check("clear2_visible", 64'(visible), 64'(AllOnes & ~((56'd1 << 0) | (56'd1 << 13))));
    check("clear2_score",   64'(score), 64'd20);

    // Bit 0 reappears on the input: must stay cleared, no credit.
    visible_in = AllOnes & ~(56'd1 << 13);
    tick();
    check("no_reset_bit0",   64'(visible[0]), 64'd0);
    check("no_reset_score",  64'(score), 64'd20);

    // start_btn is ignored in PLAY; a lives increase causes no state change.
    start_btn = 1'b1;
    lives_in  = 4'd5;
    tick();
    start_btn = 1'b0;
    check("play_ignore_start", 64'(state), 64'd2);
    lives_in = 4'd9;
    tick();
    check("play_lives_up", 64'(state), 64'd2);

    // Lives run out: 9 -> 1 -> 0.
    lives_in = 4'd1;
    tick();
    check("lives1_state", 64'(state), 64'd2);
    lives_in = 4'd0;
    tick();
    check("lost_state",     64'(state), 64'd4);
    check("lost_game_over", 64'(game_over), 64'd1);
    check("lost_game_won",  64'(game_won), 64'd0);
    check("lost_ball_rst",  64'(ball_rst), 64'd1);
    visible_in = '0;
    tick();
    check("lost_score_frozen", 64'(score), 64'd20);
    check("lost_state_hold",   64'(state), 64'd4);

    // Restart from LOST: score and mask reinitialised.
    lives_in   = 4'd9;
    visible_in = AllOnes;
    start_btn  = 1'b1;
    tick();
    start_btn = 1'b0;
    check("restart_state",   64'(state), 64'd1);
    check("restart_score",   64'(score), 64'd0);
    check("restart_visible", 64'(visible), 64'(AllOnes));
    for (int i = 0; i < 4; i++) tick();
    check("restart_play", 64'(state), 64'd2);

    // Leave only brick 5, then clear it in the same cycle lives hits zero.
    visible_in = 56'd1 << 5;
    tick();
    check("one_left_score", 64'(score), 64'd550);
    check("one_left_state", 64'(state), 64'd2);
    visible_in = '0;
    lives_in   = 4'd0;
    tick();
    check("won_state",     64'(state), 64'd3);
    check("won_game_won",  64'(game_won), 64'd1);
    check("won_game_over", 64'(game_over), 64'd0);
    check("won_score",     64'(score), 64'd560);
    check("won_ball_rst",  64'(ball_rst), 64'd1);

    // Mid-PLAY asynchronous reset with score 120.
    lives_in   = 4'd9;
    visible_in = AllOnes;
    start_game();
    check("game3_play", 64'(state), 64'd2);
    visible_in = AllOnes & ~56'hFFF;
    tick();
    check("game3_score", 64'(score), 64'd120);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state",   64'(state), 64'd0);
    check("async_rst_score",   64'(score), 64'd0);
    check("async_rst_visible", 64'(visible), 64'(AllOnes));
    check("async_rst_brst",    64'(ball_rst), 64'd1);
    @(negedge clk);
    rst        = 1'b0;
    visible_in = AllOnes;

    // Saturation: 50 bricks -> 60000, then 6 more would be 67200.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("sat_play", 64'(state_sat), 64'd2);
    vis_s = 56'h3F << 50;
    tick();
    check("sat_pre_score", 64'(score_sat), 64'd60000);
    vis_s = '0;
    tick();
    check("sat_score", 64'(score_sat), 64'hFFFF);
    check("sat_won",   64'(state_sat), 64'd3);
    tick();
    check("sat_hold",  64'(score_sat), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
